// File: rtl/mem_rd_arbiter_if.sv
// Request/grant/return bundle between the tx read controllers, the read arbiter
// and the packet buffer read port. Names are from the arbiter's point of view.
interface mem_rd_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 64
);
  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]             rd_req_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr_i;
  logic [NUM_PORTS-1:0]             rd_lock_i;
  logic [NUM_PORTS-1:0]             rd_gnt_o;
  logic [NUM_PORTS-1:0]             rd_rvalid_o;
  logic [BLOCK_BITS-1:0]            rd_rdata_o;
  logic                             mem_re_o;
  logic [ADDR_W-1:0]                mem_raddr_o;
  logic [BLOCK_BITS-1:0]            mem_rdata_i;
  logic [PTR_W-1:0]                 owner_o;
  logic                             locked_o;

  modport slave (
    input  rd_req_i, rd_addr_i, rd_lock_i, mem_rdata_i,
    output rd_gnt_o, rd_rvalid_o, rd_rdata_o, mem_re_o, mem_raddr_o, owner_o, locked_o
  );

  modport master (
    output rd_req_i, rd_addr_i, rd_lock_i, mem_rdata_i,
    input  rd_gnt_o, rd_rvalid_o, rd_rdata_o, mem_re_o, mem_raddr_o, owner_o, locked_o
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Work-conserving round-robin arbiter for the shared packet buffer read port,
// with burst locking and a tag pipeline that steers returning data to its requester.
module mem_rd_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 64,
  parameter int RD_LAT     = 2,
  parameter int MAX_BURST  = 8
) (
  input logic             clk,
  input logic             rst_n,
  mem_rd_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  logic [0:0]                   state_q, state_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [PTR_W-1:0]             owner_q, owner_d;
  logic [CNT_W-1:0]             burstCnt_q, burstCnt_d;
  logic [RD_LAT-1:0]            tagValid_q, tagValid_d;
  logic [RD_LAT-1:0][PTR_W-1:0] tagPort_q, tagPort_d;

  logic                 scanFound;
  logic [PTR_W-1:0]     scanPort;
  int                   scanIdx;
  logic                 ownerHolds;
  logic                 gntValid;
  logic [PTR_W-1:0]     gntPort;
  logic [NUM_PORTS-1:0] gntVec;
  logic                 rvalidAny;
  logic [NUM_PORTS-1:0] rvalidVec;

  function automatic logic [PTR_W-1:0] nextPort(input logic [PTR_W-1:0] p);
    return (p == LAST_PORT) ? '0 : p + PTR_W'(1);
  endfunction

  // Walk downward so the last hit written is the one closest to the pointer.
  always_comb begin
    scanFound = 1'b0;
    scanPort  = '0;
    scanIdx   = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      scanIdx = int'(ptr_q) + i;
      if (scanIdx >= NUM_PORTS) scanIdx = scanIdx - NUM_PORTS;
      if (bus.rd_req_i[PTR_W'(scanIdx)]) begin
        scanFound = 1'b1;
        scanPort  = PTR_W'(scanIdx);
      end
    end
  end

  assign ownerHolds = (state_q == ST_LOCKED) && bus.rd_req_i[owner_q];

  // While locked the pointer already sits at owner+1, so a dropped owner falls
  // straight through to a normal scan in the same cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    burstCnt_d = burstCnt_q;
    gntValid   = 1'b0;
    gntPort    = '0;
    if (ownerHolds) begin
      gntValid   = 1'b1;
      gntPort    = owner_q;
      burstCnt_d = burstCnt_q + CNT_W'(1);
      if (!bus.rd_lock_i[owner_q] || (burstCnt_d == CNT_W'(MAX_BURST))) begin
        state_d = ST_ARB;
        ptr_d   = nextPort(owner_q);
      end
    end else begin
      state_d = ST_ARB;
      if (scanFound) begin
        gntValid = 1'b1;
        gntPort  = scanPort;
        ptr_d    = nextPort(scanPort);
        if (bus.rd_lock_i[scanPort] && (MAX_BURST > 1)) begin
          state_d    = ST_LOCKED;
          owner_d    = scanPort;
          burstCnt_d = CNT_W'(1);
        end
      end
    end
    if (!rst_n) gntValid = 1'b0;
  end

  always_comb begin
    gntVec = '0;
    if (gntValid) gntVec[gntPort] = 1'b1;
  end

  assign tagValid_d = (tagValid_q << 1) | RD_LAT'(gntValid);
  assign tagPort_d  = (tagPort_q << PTR_W) | (RD_LAT * PTR_W)'(gntPort);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      burstCnt_q <= '0;
      tagValid_q <= '0;
      tagPort_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      burstCnt_q <= burstCnt_d;
      tagValid_q <= tagValid_d;
      tagPort_q  <= tagPort_d;
    end
  end

  assign rvalidAny = rst_n && tagValid_q[RD_LAT-1];

  always_comb begin
    rvalidVec = '0;
    if (rvalidAny) rvalidVec[tagPort_q[RD_LAT-1]] = 1'b1;
  end

  assign bus.rd_gnt_o    = gntVec;
  assign bus.mem_re_o    = gntValid;
  assign bus.mem_raddr_o = gntValid ? bus.rd_addr_i[gntPort] : '0;
  assign bus.rd_rvalid_o = rvalidVec;
  assign bus.rd_rdata_o  = rvalidAny ? bus.mem_rdata_i : '0;
  assign bus.locked_o    = rst_n && (state_q == ST_LOCKED);
  assign bus.owner_o     = rst_n ? owner_q : '0;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed vector table, reset corner
// sequence and randomized traffic against a cycle-level reference model.
module tb_mem_rd_arbiter;
  localparam int NUM_PORTS  = 4;
  localparam int ADDR_W     = 10;
  localparam int BLOCK_BITS = 64;
  localparam int RD_LAT     = 2;
  localparam int MAX_BURST  = 8;
  localparam int PTR_W      = $clog2(NUM_PORTS);

  typedef struct {
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] lock;
    int                   expGnt;
    int                   expLocked;
  } vec_t;

  typedef struct {
    int due;
    int port;
  } tag_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [BLOCK_BITS-1:0] memData;
  logic [ADDR_W-1:0]     addrs[$];
  int                    checks = 0;
  int                    failures = 0;
  int                    cycleNo = 0;

  int   mPtr = 0;
  int   mOwner = -1;
  int   mBurst = 0;
  tag_t pend[$];

  mem_rd_arbiter_if #(.NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .BLOCK_BITS(BLOCK_BITS)) bus ();

  mem_rd_arbiter #(
    .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .BLOCK_BITS(BLOCK_BITS),
    .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic bit bitAt(input logic [NUM_PORTS-1:0] v, input int i);
    logic [NUM_PORTS-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  task automatic compare(input string name, input logic [BLOCK_BITS-1:0] act,
                         input logic [BLOCK_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cycleNo, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_PORTS-1:0] req, input logic [NUM_PORTS-1:0] lock,
                               input logic rstVal);
    rst_n         = rstVal;
    bus.rd_req_i  = req;
    bus.rd_lock_i = lock;
    for (int p = 0; p < NUM_PORTS; p++) bus.rd_addr_i[PTR_W'(p)] = addrs[p];
    memData         = {$urandom, $urandom};
    bus.mem_rdata_i = memData;
  endtask

  // expGnt: -2 = no table value, -1 = no grant; expLocked: -1 = no table value.
  task automatic checkOutput(input string name, input int expGnt, input int expLocked);
    int                   g;
    int                   rv;
    logic                 inReset;
    logic                 lockedNow;
    int                   ownerNow;
    logic [NUM_PORTS-1:0] reqV;
    logic [NUM_PORTS-1:0] lockV;
    logic [NUM_PORTS-1:0] expGntVec;
    logic [NUM_PORTS-1:0] expRvVec;
    @(negedge clk);
    reqV      = bus.rd_req_i;
    lockV     = bus.rd_lock_i;
    inReset   = (rst_n !== 1'b1);
    lockedNow = !inReset && (mOwner >= 0);
    ownerNow  = lockedNow ? mOwner : 0;

    g = -1;
    if (!inReset) begin
      if (mOwner >= 0 && bitAt(reqV, mOwner)) begin
        g = mOwner;
        mBurst++;
        if (!bitAt(lockV, mOwner) || mBurst == MAX_BURST) begin
          mPtr   = (mOwner + 1) % NUM_PORTS;
          mOwner = -1;
        end
      end else begin
        mOwner = -1;
        for (int i = 0; i < NUM_PORTS; i++)
          if (g < 0 && bitAt(reqV, (mPtr + i) % NUM_PORTS)) g = (mPtr + i) % NUM_PORTS;
        if (g >= 0) begin
          mPtr = (g + 1) % NUM_PORTS;
          if (bitAt(lockV, g) && MAX_BURST > 1) begin
            mOwner = g;
            mBurst = 1;
          end
        end
      end
    end

    rv = -1;
    if (pend.size() > 0 && pend[0].due == cycleNo) begin
      rv = pend[0].port;
      void'(pend.pop_front());
    end
    if (inReset) rv = -1;

    expGntVec = '0;
    if (g >= 0) expGntVec = NUM_PORTS'(1) << g;
    expRvVec = '0;
    if (rv >= 0) expRvVec = NUM_PORTS'(1) << rv;

    compare({name, ".gnt"}, bus.rd_gnt_o, expGntVec);
    compare({name, ".mem_re"}, bus.mem_re_o, g >= 0);
    compare({name, ".raddr"}, bus.mem_raddr_o, (g >= 0) ? addrs[g] : '0);
    compare({name, ".rvalid"}, bus.rd_rvalid_o, expRvVec);
    compare({name, ".rdata"}, bus.rd_rdata_o, (rv >= 0) ? memData : '0);
    compare({name, ".locked"}, bus.locked_o, lockedNow);
    if (lockedNow || inReset) compare({name, ".owner"}, bus.owner_o, ownerNow);
    if (expGnt != -2)
      compare({name, ".tblGnt"}, bus.rd_gnt_o, (expGnt >= 0) ? (NUM_PORTS'(1) << expGnt) : '0);
    if (expLocked >= 0) compare({name, ".tblLocked"}, bus.locked_o, expLocked != 0);

    if (g >= 0) pend.push_back('{cycleNo + RD_LAT, g});
    if (inReset) begin
      mPtr   = 0;
      mOwner = -1;
      mBurst = 0;
      pend.delete();
    end
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  initial begin
    vec_t vecs[$];
    addrs = '{10'h010, 10'h020, 10'h030, 10'h040};

    applyStimulus('0, '0, 1'b0);
    checkOutput("reset0", -1, 0);
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    checkOutput("reset1", -1, 0);

    for (int k = 0; k < 5; k++) vecs.push_back('{4'b1111, 4'b0000, k % 4, 0});
    vecs.push_back('{4'b1001, 4'b0000, 3, 0});
    vecs.push_back('{4'b1001, 4'b0000, 0, 0});
    vecs.push_back('{4'b1001, 4'b0000, 3, 0});
    for (int k = 0; k < 3; k++) vecs.push_back('{4'b0100, 4'b0000, 2, 0});
    vecs.push_back('{4'b0000, 4'b0000, -1, 0});
    vecs.push_back('{4'b0001, 4'b0000, 0, 0});
    for (int k = 0; k < MAX_BURST; k++) vecs.push_back('{4'b1111, 4'b0010, 1, (k == 0) ? 0 : 1});
    vecs.push_back('{4'b1111, 4'b0010, 2, 0});
    vecs.push_back('{4'b0001, 4'b0001, 0, 0});
    vecs.push_back('{4'b0001, 4'b0001, 0, 1});
    vecs.push_back('{4'b0001, 4'b0001, 0, 1});
    vecs.push_back('{4'b1000, 4'b0000, 3, 1});
    vecs.push_back('{4'b0000, 4'b0000, -1, 0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].lock, 1'b1);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expLocked);
    end

    // Reset while locked with two reads in flight: both must vanish.
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    checkOutput("rstA", 2, 0);
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    checkOutput("rstB", 2, 1);
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkOutput("rstC", -1, 0);
    for (int k = 0; k <= RD_LAT; k++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput($sformatf("rstIdle%0d", k), -1, 0);
      compare("rstNoRvalid", bus.rd_rvalid_o, '0);
    end
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("rstFirst", 0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0)
        for (int p = 0; p < NUM_PORTS; p++) addrs[p] = ADDR_W'($urandom);
      applyStimulus(NUM_PORTS'($urandom), NUM_PORTS'($urandom | $urandom),
                    ($urandom_range(0, 149) != 0));
      checkOutput("rand", -2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
